// File: rtl/fir_accum_sched_pkg.sv
// fir_sched_pkg: shared state type, default sizes and idx-width helper for fir_accum_sched
package fir_sched_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int FIR_W = 16;
  localparam int FIR_NTAPS = 8;
  localparam int FIR_IDX_W = $clog2(FIR_NTAPS);
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fir_accum_sched_if.sv
// fir_accum_sched_if: tap-vector input and accumulated-result output handshakes
interface fir_accum_sched_if import fir_sched_pkg::*; #(
  parameter int NTAPS = FIR_NTAPS,
  parameter int W = FIR_W
);
  logic in_valid;
  logic in_ready;
  logic [NTAPS*W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic out_ovf;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_ovf);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_ovf);
endinterface

// File: rtl/fir_accum_sched_tap_select.sv
// fir_tap_select: NTAPS:1 tap multiplexer feeding the shared adder, zero when disabled
module fir_tap_select #(
  parameter int NTAPS = 8,
  parameter int W = 16,
  parameter int IW = 3
) (
  input  logic en,
  input  logic [IW-1:0] sel,
  input  logic [NTAPS-1:0][W-1:0] taps,
  output logic [W-1:0] y
);
  assign y = en ? taps[sel] : '0;
endmodule

// File: rtl/fir_accum_sched.sv
// fir_accum_sched: sequences NTAPS products one per cycle through an external shared adder.
// Define FIR_ACC_SAT_EN to saturate the accumulator to all-ones on the first carry.
module fir_accum_sched import fir_sched_pkg::*; #(
  parameter int NTAPS = FIR_NTAPS,
  parameter int W = FIR_W
) (
  input  logic clk,
  input  logic rst_n,
  fir_accum_sched_if.slave bus,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_s,
  input  logic add_cout
);
  localparam int IW = idx_w(NTAPS);
  localparam logic [IW-1:0] LAST = IW'(NTAPS - 1);
  state_t state, state_n;
  logic [NTAPS-1:0][W-1:0] prods;
  logic [W-1:0] acc, acc_n;
  logic [IW-1:0] idx;
  logic ovf, accum, done, last, accept;
  always_comb begin
    accum = state == ACCUM;
    done = state == DONE;
    last = idx == LAST;
    accept = state == IDLE && bus.in_valid;
    bus.in_ready = state == IDLE;
    bus.out_valid = done;
    bus.out_data = done ? acc : '0;
    bus.out_ovf = done & ovf;
    add_a = accum ? acc : '0;
`ifdef FIR_ACC_SAT_EN
    acc_n = (ovf | add_cout) ? '1 : add_s;
`else
    acc_n = add_s;
`endif
    state_n = accept ? ACCUM : (accum && last) ? DONE : (done && bus.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prods <= '0;
      acc <= '0;
      idx <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      prods <= bus.in_data;
      acc <= '0;
      idx <= '0;
      ovf <= 1'b0;
    end else if (accum) begin
      acc <= acc_n;
      ovf <= ovf | add_cout;
      idx <= last ? '0 : idx + 1'b1;
    end
  fir_tap_select #(.NTAPS(NTAPS), .W(W), .IW(IW)) u_sel (
    .en(accum),
    .sel(idx),
    .taps(prods),
    .y(add_b)
  );
endmodule
